// File: rtl/fpmul_pkg.sv
// Shared definitions for the floating-point multiplier and its rounding stage:
// rounding-mode encodings, flag bit positions, exponent bias and canonical qNaN.
package fpmul_pkg;

   typedef enum logic [1:0] {
      RM_RNE = 2'b00,
      RM_RTZ = 2'b01,
      RM_RUP = 2'b10,
      RM_RDN = 2'b11
   } rmode_e;

   localparam int FLG_INEXACT   = 3;
   localparam int FLG_UNDERFLOW = 2;
   localparam int FLG_OVERFLOW  = 1;
   localparam int FLG_INVALID   = 0;

   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // Returned wide; callers keep the low 1+exp_w+man_w bits.
   function automatic logic [127:0] fp_qnan(input int exp_w, input int man_w);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < exp_w; i++) r[man_w + i] = 1'b1;
      r[man_w - 1] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/fpmul_pipe_if.sv
// Operand/result handshake bundle for fpmul_pipe; master is the producer/consumer
// side, slave is the multiplier.
interface fpmul_pipe_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) ();
   localparam int W = 1 + EXP_W + MAN_W;

   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [1:0]    rmode;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  y;
   logic [3:0]    flags;

   modport master (
      output in_valid, a, b, rmode, out_ready,
      input  in_ready, out_valid, y, flags
   );

   modport slave (
      input  in_valid, a, b, rmode, out_ready,
      output in_ready, out_valid, y, flags
   );
endinterface

// File: rtl/fpmul_round.sv
// Combinational normalise/round/assemble for a [1,4) significand product with FTZ output.
// No state; latency 0, no handshake of its own.
module fpmul_round
   import fpmul_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                     sign,
   input  logic signed [EXP_W+1:0]  exp_in,
   input  logic [2*MAN_W+1:0]       sig,
   input  rmode_e                   rm,
   output logic [EXP_W+MAN_W:0]     y,
   output logic [3:0]               flags
);
   localparam int EW = EXP_W + 2;
   localparam logic signed [EW-1:0] E_ONE    = EW'(1);
   localparam logic signed [EW-1:0] E_MAX    = EW'((1 << EXP_W) - 1);
   localparam logic [EXP_W-1:0]     EXP_ONES = '1;
   localparam logic [EXP_W-1:0]     EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};

   logic [2*MAN_W:0]       nrm;
   logic signed [EW-1:0]   e_n;
   logic signed [EW-1:0]   e_r;
   logic [MAN_W:0]         frac;
   logic                   g;
   logic                   s;
   logic                   inc;
   logic                   ovf_inf;

   always_comb begin
      nrm     = '0;
      e_n     = exp_in;
      inc     = 1'b0;
      y       = '0;
      flags   = '0;

      // nrm drops the hidden one: its MSB is the first fraction bit.
      if (sig[2*MAN_W+1]) begin
         nrm = sig[2*MAN_W:0];
         e_n = exp_in + E_ONE;
      end else begin
         nrm = {sig[2*MAN_W-1:0], 1'b0};
      end

      g = nrm[MAN_W];
      s = |nrm[MAN_W-1:0];

      case (rm)
         RM_RNE:  inc = g & (s | nrm[MAN_W+1]);
         RM_RUP:  inc = (g | s) & ~sign;
         RM_RDN:  inc = (g | s) & sign;
         default: inc = 1'b0;
      endcase

      frac = {1'b0, nrm[2*MAN_W:MAN_W+1]} + {{MAN_W{1'b0}}, inc};
      e_r  = frac[MAN_W] ? e_n + E_ONE : e_n;
      ovf_inf = (rm == RM_RNE) | ((rm == RM_RUP) & ~sign) | ((rm == RM_RDN) & sign);

      y = {sign, e_r[EXP_W-1:0], frac[MAN_W-1:0]};
      flags[FLG_INEXACT] = g | s;

      if (e_n[EW-1] || e_n == '0) begin
         y = {sign, {(EXP_W+MAN_W){1'b0}}};
         flags[FLG_INEXACT]   = 1'b1;
         flags[FLG_UNDERFLOW] = 1'b1;
      end else if (e_r >= E_MAX) begin
         flags[FLG_INEXACT]  = 1'b1;
         flags[FLG_OVERFLOW] = 1'b1;
         if (ovf_inf) y = {sign, EXP_ONES, {MAN_W{1'b0}}};
         else         y = {sign, EXP_MAXF, {MAN_W{1'b1}}};
      end
   end
endmodule

// File: rtl/fpmul_pipe.sv
// fpmul_pipe: 3-stage FP multiplier (classify/exp, multiply, round), FTZ, 4 rounding modes.
// Whole pipe stalls while out_valid & ~out_ready; FPMUL_STICKY_FLAGS_EN adds sticky flags.
module fpmul_pipe
   import fpmul_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic          clk,
   input  logic          reset,
   fpmul_pipe_if.slave   bus
`ifdef FPMUL_STICKY_FLAGS_EN
   ,
   input  logic          flag_clr,
   output logic [3:0]    sticky_flags
`endif
);
   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int EW   = EXP_W + 2;
   localparam int PW   = 2*MAN_W + 2;
   localparam int BIAS = fp_bias(EXP_W);
   localparam logic [127:0]          QNAN_FULL = fp_qnan(EXP_W, MAN_W);
   localparam logic [W-1:0]          QNAN      = QNAN_FULL[W-1:0];
   localparam logic signed [EW-1:0]  BIAS_X    = EW'(BIAS);
   localparam logic [EXP_W-1:0]      EXP_ONES  = '1;

   logic advance;

   logic                sa, sb;
   logic [EXP_W-1:0]    ea, eb;
   logic [MAN_W-1:0]    fa, fb;
   logic                a_zero, b_zero, a_max, b_max;
   logic                a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
   logic                in_sign;
   logic                in_spec;
   logic [W-1:0]        spec_y;
   logic [3:0]          spec_f;
   logic signed [EW-1:0] e_sum;

   logic                s1_vld, s1_sign, s1_spec;
   logic signed [EW-1:0] s1_exp;
   logic [MAN_W:0]      s1_ma, s1_mb;
   rmode_e              s1_rm;
   logic [W-1:0]        s1_spec_y;
   logic [3:0]          s1_spec_f;

   logic                s2_vld, s2_sign, s2_spec;
   logic signed [EW-1:0] s2_exp;
   logic [PW-1:0]       s2_prod;
   rmode_e              s2_rm;
   logic [W-1:0]        s2_spec_y;
   logic [3:0]          s2_spec_f;

   logic [W-1:0]        rnd_y;
   logic [3:0]          rnd_f;
   logic                out_vld;
   logic [W-1:0]        y_q;
   logic [3:0]          flags_q;

   assign advance       = bus.out_ready | ~out_vld;
   assign bus.in_ready  = advance;
   assign bus.out_valid = out_vld;
   assign bus.y         = y_q;
   assign bus.flags     = flags_q;

   assign {sa, ea, fa} = bus.a;
   assign {sb, eb, fb} = bus.b;

   // Denormals have a zero exponent field and therefore classify as zero.
   assign a_zero  = (ea == '0);
   assign b_zero  = (eb == '0);
   assign a_max   = (ea == EXP_ONES);
   assign b_max   = (eb == EXP_ONES);
   assign a_inf   = a_max && (fa == '0);
   assign b_inf   = b_max && (fb == '0);
   assign a_nan   = a_max && (fa != '0);
   assign b_nan   = b_max && (fb != '0);
   assign a_snan  = a_nan && !fa[MAN_W-1];
   assign b_snan  = b_nan && !fb[MAN_W-1];
   assign in_sign = sa ^ sb;
   assign in_spec = a_zero | b_zero | a_max | b_max;
   assign e_sum   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_X;

   always_comb begin
      spec_y = '0;
      spec_f = '0;
      if (a_nan || b_nan) begin
         spec_y = QNAN;
         spec_f[FLG_INVALID] = a_snan | b_snan;
      end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
         spec_y = QNAN;
         spec_f[FLG_INVALID] = 1'b1;
      end else if (a_inf || b_inf) begin
         spec_y = {in_sign, EXP_ONES, {MAN_W{1'b0}}};
      end else begin
         spec_y = {in_sign, {(W-1){1'b0}}};
      end
   end

   // Datapath registers carry no reset; the valid bits qualify them.
   always_ff @(posedge clk) begin
      if (advance) begin
         if (bus.in_valid) begin
            s1_sign   <= in_sign;
            s1_exp    <= e_sum;
            s1_ma     <= {1'b1, fa};
            s1_mb     <= {1'b1, fb};
            s1_rm     <= rmode_e'(bus.rmode);
            s1_spec   <= in_spec;
            s1_spec_y <= spec_y;
            s1_spec_f <= spec_f;
         end
         if (s1_vld) begin
            s2_sign   <= s1_sign;
            s2_exp    <= s1_exp;
            s2_prod   <= PW'(s1_ma) * PW'(s1_mb);
            s2_rm     <= s1_rm;
            s2_spec   <= s1_spec;
            s2_spec_y <= s1_spec_y;
            s2_spec_f <= s1_spec_f;
         end
      end
   end

   fpmul_round #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_round (
      .sign   (s2_sign),
      .exp_in (s2_exp),
      .sig    (s2_prod),
      .rm     (s2_rm),
      .y      (rnd_y),
      .flags  (rnd_f)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_vld  <= 1'b0;
         s2_vld  <= 1'b0;
         out_vld <= 1'b0;
         y_q     <= '0;
         flags_q <= '0;
      end else if (advance) begin
         s1_vld  <= bus.in_valid;
         s2_vld  <= s1_vld;
         out_vld <= s2_vld;
         if (s2_vld) begin
            y_q     <= s2_spec ? s2_spec_y : rnd_y;
            flags_q <= s2_spec ? s2_spec_f : rnd_f;
         end
      end
   end

`ifdef FPMUL_STICKY_FLAGS_EN
   logic out_xfer;
   assign out_xfer = out_vld & bus.out_ready;

   // A clear coinciding with a transfer keeps only the transferring result's flags.
   always_ff @(posedge clk) begin
      if (reset)         sticky_flags <= '0;
      else if (flag_clr) sticky_flags <= out_xfer ? flags_q : 4'b0000;
      else if (out_xfer) sticky_flags <= sticky_flags | flags_q;
   end
`endif
endmodule

// File: tb/tb_fpmul_pipe.sv
// Directed bench for fpmul_pipe at binary32 widths with hand-computed expected results.
module tb_fpmul_pipe;
   localparam int EXP_W = 8;
   localparam int MAN_W = 23;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  rm;
      logic [31:0] y;
      logic [3:0]  f;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   fpmul_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

`ifdef FPMUL_STICKY_FLAGS_EN
   logic       flag_clr = 1'b0;
   logic [3:0] sticky_flags;
`endif

   fpmul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus)
`ifdef FPMUL_STICKY_FLAGS_EN
      ,
      .flag_clr     (flag_clr),
      .sticky_flags (sticky_flags)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Issues one operation into an empty pipe and waits (bounded) for its result.
   task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic [1:0] rm,
                         output logic [31:0] oy, output logic [3:0] of, output int lat);
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.a         = ia;
      bus.b         = ib;
      bus.rmode     = rm;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      if (bus.out_valid === 1'b1) begin
         oy = bus.y;
         of = bus.flags;
      end else begin
         oy  = 'x;
         of  = 'x;
         lat = -1;
      end
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.rmode     = 2'b00;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
      checks++; if (bus.y !== 32'h0) begin errors++; $display("FAIL reset_y got %h want 00000000", bus.y); end
      checks++; if (bus.flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", bus.flags); end
      reset = 1'b0;
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
   endtask

   task automatic test_basic();
      logic [31:0] y;
      logic [3:0]  f;
      int          lat;
      run_op(32'h3FC00000, 32'h40000000, 2'b00, y, f, lat);
      checks++; if (y !== 32'h40400000) begin errors++; $display("FAIL basic_y got %h want 40400000", y); end
      checks++; if (f !== 4'b0000) begin errors++; $display("FAIL basic_flags got %b want 0000", f); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency got %0d want 3", lat); end
   endtask

   task automatic test_overflow();
      vec_t vs [5] = '{
         '{32'h7F000000, 32'h7F000000, 2'b00, 32'h7F800000, 4'b1010},
         '{32'h7F000000, 32'h7F000000, 2'b01, 32'h7F7FFFFF, 4'b1010},
         '{32'h7F000000, 32'h7F000000, 2'b11, 32'h7F7FFFFF, 4'b1010},
         '{32'hFF000000, 32'h7F000000, 2'b11, 32'hFF800000, 4'b1010},
         '{32'h7F7FFFFF, 32'h3F800000, 2'b00, 32'h7F7FFFFF, 4'b0000}
      };
      logic [31:0] y;
      logic [3:0]  f;
      int          lat;
      for (int i = 0; i < 5; i++) begin
         run_op(vs[i].a, vs[i].b, vs[i].rm, y, f, lat);
         checks++;
         if (y !== vs[i].y || f !== vs[i].f) begin
            errors++;
            $display("FAIL overflow[%0d] got y=%h flags=%b want y=%h flags=%b", i, y, f, vs[i].y, vs[i].f);
         end
      end
   endtask

   task automatic test_specials();
      vec_t vs [7] = '{
         '{32'h7F800000, 32'h00000000, 2'b00, 32'h7FC00000, 4'b0001},
         '{32'h00000000, 32'hFF800000, 2'b00, 32'h7FC00000, 4'b0001},
         '{32'h7F800001, 32'h3F800000, 2'b00, 32'h7FC00000, 4'b0001},
         '{32'h7FC00000, 32'h3F800000, 2'b00, 32'h7FC00000, 4'b0000},
         '{32'h7FC00000, 32'hFF800001, 2'b00, 32'h7FC00000, 4'b0001},
         '{32'hFF800000, 32'h40000000, 2'b00, 32'hFF800000, 4'b0000},
         '{32'h80000000, 32'h3F800000, 2'b00, 32'h80000000, 4'b0000}
      };
      logic [31:0] y;
      logic [3:0]  f;
      int          lat;
      for (int i = 0; i < 7; i++) begin
         run_op(vs[i].a, vs[i].b, vs[i].rm, y, f, lat);
         checks++;
         if (y !== vs[i].y || f !== vs[i].f) begin
            errors++;
            $display("FAIL special[%0d] got y=%h flags=%b want y=%h flags=%b", i, y, f, vs[i].y, vs[i].f);
         end
      end
   endtask

   task automatic test_rounding();
      vec_t vs [8] = '{
         '{32'h3F800001, 32'h3F800001, 2'b00, 32'h3F800002, 4'b1000},
         '{32'hBF800001, 32'h3F800001, 2'b11, 32'hBF800003, 4'b1000},
         '{32'hBF800001, 32'h3F800001, 2'b01, 32'hBF800002, 4'b1000},
         '{32'h3F800001, 32'h3F800001, 2'b10, 32'h3F800003, 4'b1000},
         '{32'h3FC00000, 32'h3F800001, 2'b00, 32'h3FC00002, 4'b1000},
         '{32'h3FC00000, 32'h3F800003, 2'b00, 32'h3FC00004, 4'b1000},
         '{32'h3FFFFFFE, 32'h3F800001, 2'b00, 32'h40000000, 4'b1000},
         '{32'h3FC00000, 32'h40000000, 2'b10, 32'h40400000, 4'b0000}
      };
      logic [31:0] y;
      logic [3:0]  f;
      int          lat;
      for (int i = 0; i < 8; i++) begin
         run_op(vs[i].a, vs[i].b, vs[i].rm, y, f, lat);
         checks++;
         if (y !== vs[i].y || f !== vs[i].f) begin
            errors++;
            $display("FAIL rounding[%0d] got y=%h flags=%b want y=%h flags=%b", i, y, f, vs[i].y, vs[i].f);
         end
      end
   endtask

   task automatic test_underflow();
      vec_t vs [5] = '{
         '{32'h00800000, 32'h3F000000, 2'b00, 32'h00000000, 4'b1100},
         '{32'h00800000, 32'h3F000000, 2'b10, 32'h00000000, 4'b1100},
         '{32'h80800000, 32'h3F000000, 2'b00, 32'h80000000, 4'b1100},
         '{32'h00000001, 32'h40000000, 2'b00, 32'h00000000, 4'b0000},
         '{32'h00800000, 32'h3F800000, 2'b00, 32'h00800000, 4'b0000}
      };
      logic [31:0] y;
      logic [3:0]  f;
      int          lat;
      for (int i = 0; i < 5; i++) begin
         run_op(vs[i].a, vs[i].b, vs[i].rm, y, f, lat);
         checks++;
         if (y !== vs[i].y || f !== vs[i].f) begin
            errors++;
            $display("FAIL underflow[%0d] got y=%h flags=%b want y=%h flags=%b", i, y, f, vs[i].y, vs[i].f);
         end
      end
   endtask

   // Six ops 1.5*2^k times 2.0 (result 1.5*2^(k+1)) with the consumer stalled in cycles 2-7.
   task automatic test_back_to_back();
      int          sent = 0;
      int          recv = 0;
      int          c = 0;
      logic        prev_stall = 1'b0;
      logic [31:0] prev_y = '0;
      logic        saw_block = 1'b0;
      logic        acc;
      logic [31:0] exp_y;
      @(posedge clk); #1;
      while (recv < 6 && c < 60) begin
         bus.in_valid  = (sent < 6);
         bus.a         = 32'h3FC00000 + (32'(sent) << 23);
         bus.b         = 32'h40000000;
         bus.rmode     = 2'b00;
         bus.out_ready = !(c >= 2 && c <= 7);
         @(negedge clk);
         if (prev_stall) begin
            checks++;
            if (bus.y !== prev_y) begin errors++; $display("FAIL b2b_hold cycle %0d got y=%h want %h", c, bus.y, prev_y); end
         end
         if (sent < 6 && bus.in_ready === 1'b0) saw_block = 1'b1;
         acc = bus.in_valid && bus.in_ready;
         if (bus.out_valid === 1'b1 && bus.out_ready) begin
            exp_y = 32'h3FC00000 + (32'(recv + 1) << 23);
            checks++;
            if (bus.y !== exp_y || bus.flags !== 4'b0000) begin
               errors++;
               $display("FAIL b2b_result[%0d] got y=%h flags=%b want y=%h flags=0000", recv, bus.y, bus.flags, exp_y);
            end
            recv++;
         end
         prev_stall = (bus.out_valid === 1'b1) && !bus.out_ready;
         prev_y     = bus.y;
         if (acc) sent++;
         @(posedge clk); #1;
         c++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      checks++; if (recv !== 6) begin errors++; $display("FAIL b2b_count got %0d want 6", recv); end
      checks++; if (saw_block !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_drop got %b want 1", saw_block); end
   endtask

   task automatic test_reset_flush();
      logic        stale = 1'b0;
      logic [31:0] y;
      logic [3:0]  f;
      int          lat;
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.a         = 32'h3FC00000;
      bus.b         = 32'h40000000;
      bus.rmode     = 2'b00;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.a = 32'h40000000;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", bus.out_valid); end
      checks++; if (bus.y !== 32'h0) begin errors++; $display("FAIL flush_y got %h want 00000000", bus.y); end
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b0) stale = 1'b1;
      end
      checks++; if (stale !== 1'b0) begin errors++; $display("FAIL flush_stale got %b want 0", stale); end
      run_op(32'h3FC00000, 32'h40000000, 2'b00, y, f, lat);
      checks++; if (y !== 32'h40400000 || f !== 4'b0000) begin errors++; $display("FAIL flush_resume got y=%h flags=%b want y=40400000 flags=0000", y, f); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_specials();
      test_rounding();
      test_underflow();
      test_back_to_back();
      test_reset_flush();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
